serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing DIFF = A - B, LSB first, one bit per clock.
- Datapath cell is a full subtractor (difference and borrow), the arithmetic counterpart of the team's half adder.
- A borrow flip-flop chains successive bits.
- Used where area matters more than latency; a START/BUSY/DONE handshake lets a controller or bench sequence operations.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
CLK     input   1      rising-edge clock
RST_N   input   1      asynchronous, active-low reset
START   input   1      request; sampled only in IDLE
A       input   WIDTH  minuend; captured on accepted START
B       input   WIDTH  subtrahend; captured on accepted START
BUSY    output  1      high in SHIFT and FINISH states
DONE    output  1      one-cycle pulse when DIFF/BORROW update
DIFF    output  WIDTH  A - B modulo 2^WIDTH
BORROW  output  1      1 when A < B (unsigned)

Behaviour:
- Reset (RST_N low, async): state IDLE, BUSY=0, DONE=0, DIFF=0, BORROW=0, internal shift regs/counter/borrow FF = 0.
- FSM states and transitions:
  - IDLE --START--> SHIFT: load a_sh<=A, b_sh<=B, br<=0, cnt<=0.
  - SHIFT (WIDTH cycles), each cycle:
    - d = a0^b0^br
    - br <= (~a0&b0) | (~(a0^b0)&br)
    - a_sh and b_sh shift right by 1
    - r_sh <= {d, r_sh[WIDTH-1:1]}
    - cnt++
    - leaves to FINISH when cnt == WIDTH-1.
  - FINISH (1 cycle): DIFF<=r_sh, BORROW<=br, DONE=1 that cycle; -> IDLE.
- Latency: START sampled at edge N -> DONE high in cycle N+WIDTH+1; new START accepted the cycle after DONE (throughput 1 op per WIDTH+2 cycles).
- START while BUSY: ignored, no queueing. A/B changes while BUSY: no effect.
- DIFF/BORROW hold their last value until the next FINISH; they never show partial results.
- Reset mid-operation: operation aborted, all outputs return to reset values immediately; no DONE pulse.
- Counter width = $clog2(WIDTH)+1; no wrap inside an operation.

Optional Feature:
SERIAL_SUB_ADD_MODE_EN
- Defined:
  - Adds input port MODE (1 bit), captured with A/B on START.
  - MODE=1 selects addition: d = a0^b0^c, c <= (a0&b0)|((a0^b0)&c); BORROW then reports carry-out.
  - MODE=0 gives subtraction as specified above.
- Undefined: no MODE port; subtract only; identical timing either way.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE, SHIFT, FINISH), state encoding constants, default WIDTH constant.
- Sub-module full_subtractor (inputs A, B, BIN; outputs DIFF, BOUT) is the combinational per-bit cell, instantiated once inside serial_subtractor.
- Everything else (FSM, counter, shift registers) stays in serial_subtractor.

Test Plan:
- A=0x05, B=0x03, START 1 cycle -> BUSY 9 cycles, DONE pulse at cycle 9, DIFF=0x02, BORROW=0.
- A=0x03, B=0x05 -> DIFF=0xFE, BORROW=1. A=0x00, B=0x01 -> DIFF=0xFF, BORROW=1.
- A=0xFF, B=0xFF -> DIFF=0x00, BORROW=0.
- Back-to-back ops: A=0x80, B=0x01 -> DIFF=0x7F, BORROW=0. Then START held high continuously with A=0x10, B=0x20 -> second op starts the cycle after DONE, DIFF=0xF0, BORROW=1.
- Busy-ignore and reset abort:
  - Op A=0x0A, B=0x04; START re-pulsed with A=0x00, B=0xFF at cycle 3 -> ignored, DIFF=0x06, BORROW=0.
  - Then new op with RST_N low at cycle 4 -> BUSY=DONE=0, DIFF=0x00, BORROW=0 immediately; no DONE pulse afterwards.
- With SERIAL_SUB_ADD_MODE_EN:
  - MODE=1, A=0xFF, B=0x01 -> DIFF=0x00, BORROW(carry)=1.
  - MODE=0, same operands -> DIFF=0xFE, BORROW=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// FSM state encoding and the default operand width live here.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    FINISH = ST_FINISH
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: DIFF = A - B - BIN, BOUT = borrow out.
// Purely combinational cell for the serial datapath.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);

  assign DIFF = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, START/BUSY/DONE handshake.
// Optional SERIAL_SUB_ADD_MODE_EN adds a MODE port selecting addition.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             MODE,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             cell_a;
  logic             cell_d;
  logic             cell_bo;
  logic             d;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic mode_q;

  // Add mode reuses the subtractor cell: the borrow of (~a - b - c)
  // equals the carry of (a + b + c), and its difference bit is inverted.
  assign cell_a = a_sh[0] ^ mode_q;
  assign d      = cell_d ^ mode_q;
`else
  assign cell_a = a_sh[0];
  assign d      = cell_d;
`endif

  full_subtractor u_cell (
    .A    (cell_a),
    .B    (b_sh[0]),
    .BIN  (br),
    .DIFF (cell_d),
    .BOUT (cell_bo)
  );

  assign BUSY = (state != IDLE);
  assign DONE = (state == FINISH);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (START) nxt = SHIFT;
      SHIFT:   if (cnt == LAST) nxt = FINISH;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result publication
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      DIFF   <= '0;
      BORROW <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            a_sh <= A;
            b_sh <= B;
            br   <= 1'b0;
            cnt  <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q <= MODE;
`endif
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {d, r_sh[WIDTH-1:1]};
          br   <= cell_bo;
          cnt  <= cnt + 1'b1;
        end
        FINISH: begin
          DIFF   <= r_sh;
          BORROW <= br;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (scoreboard + assertions).
// Mode tests are compiled only with SERIAL_SUB_ADD_MODE_EN defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic         MODE = 1'b0;
`endif
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] DIFF;
  logic         BORROW;

  int checks = 0;
  int failures = 0;
  logic [W:0] sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .A      (A),
    .B      (B),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .MODE   (MODE),
`endif
    .BUSY   (BUSY),
    .DONE   (DONE),
    .DIFF   (DIFF),
    .BORROW (BORROW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input bit m);
    if (m) return {1'b0, a} + {1'b0, b};
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit m);
    A = a;
    B = b;
`ifdef SERIAL_SUB_ADD_MODE_EN
    MODE = m;
`endif
    START = 1'b1;
  endtask

  task automatic push_start(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit m);
    @(negedge CLK);
    drive(a, b, m);
    sb.push_back(model(a, b, m));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int n;
    bit seen;
    logic [W:0] exp;
    n = 0;
    seen = 0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      if (BUSY === 1'b1) n++;
      if (DONE === 1'b1) seen = 1;
      else @(negedge CLK);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    @(negedge CLK);
    check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_idle_done"}, 32'(DONE), 32'd0);
    check({tag, "_sb_has_entry"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_diff"}, 32'(DIFF), 32'(exp[W-1:0]));
      check({tag, "_borrow"}, 32'(BORROW), 32'(exp[W]));
    end
  endtask

  initial begin
    int dcnt;
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_diff", 32'(DIFF), 32'd0);
    check("rst_borrow", 32'(BORROW), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    push_start(8'h05, 8'h03, 0);
    wait_done("sub_5_3", W + 1);
    push_start(8'h03, 8'h05, 0);
    wait_done("sub_3_5", W + 1);
    push_start(8'h00, 8'h01, 0);
    wait_done("sub_0_1", W + 1);
    push_start(8'hFF, 8'hFF, 0);
    wait_done("sub_ff_ff", W + 1);

    push_start(8'h80, 8'h01, 0);
    drive(8'h10, 8'h20, 0);
    sb.push_back(model(8'h10, 8'h20, 0));
    wait_done("b2b_first", W + 1);
    @(negedge CLK);
    START = 1'b0;
    check("b2b_started", 32'(BUSY), 32'd1);
    wait_done("b2b_second", W + 1);

    push_start(8'h0A, 8'h04, 0);
    repeat (2) @(negedge CLK);
    drive(8'h00, 8'hFF, 0);
    @(negedge CLK);
    START = 1'b0;
    wait_done("busy_ignore", W - 2);

    @(negedge CLK);
    drive(8'h33, 8'h11, 0);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_diff", 32'(DIFF), 32'd0);
    check("abort_borrow", 32'(BORROW), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);

`ifdef SERIAL_SUB_ADD_MODE_EN
    push_start(8'hFF, 8'h01, 1);
    wait_done("add_ff_01", W + 1);
    push_start(8'hFF, 8'h01, 0);
    wait_done("modesub_ff_01", W + 1);
    push_start(8'h3C, 8'h5A, 1);
    wait_done("add_3c_5a", W + 1);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
